sr_flop_bank: RTL and testbench



---
 rtl/sr_flop_bank.sv | 97 +++++++++
 tb/tb_sr_flop_bank.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sr_flop_bank.sv
`default_nettype none
// ============================================================================
// sr_flop_bank : WIDTH synchronous SR channels with a compile-time conflict
//                mode, rise/fall pulses and a saturating conflict counter.
// Rev 1.0
// ============================================================================
module sr_flop_bank #(
  parameter int              WIDTH = 8,
  parameter int              MODE  = 0,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter int              CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qbar_q;
  logic [WIDTH-1:0] rise_q, fall_q;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] w_both_val;

  // Value a channel takes when set and clr are both asserted.
  generate
    if (MODE == 1) begin : g_mode_set
      assign w_both_val = '1;
    end else if (MODE == 2) begin : g_mode_clr
      assign w_both_val = '0;
    end else if (MODE == 3) begin : g_mode_toggle
      assign w_both_val = ~q_q;
    end else begin : g_mode_hold
      assign w_both_val = q_q;
    end
  endgenerate

  always_comb begin
    q_d        = q_q;
    conflict_d = 1'b0;
    if (en) begin
      q_d = (set & ~clr)
          | (q_q & ~set & ~clr)
          | (w_both_val & set & clr);
      conflict_d = |(set & clr);
    end
  end

  // Clear beats a same-cycle conflict; increments stop at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (conflict_d && (cnt_q != c_CNT_MAX)) begin
      cnt_d = cnt_q + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q        <= INIT;
      qbar_q     <= ~INIT;
      rise_q     <= '0;
      fall_q     <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      q_q        <= q_d;
      qbar_q     <= ~q_d;
      rise_q     <= ~q_q & q_d;
      fall_q     <= q_q & ~q_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign q            = q_q;
  assign qbar         = qbar_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_flop_bank.sv
`default_nettype none
// ============================================================================
// tb_sr_flop_bank : directed checks of four sr_flop_bank variants (MODE 0..3)
// Rev 1.0
// ============================================================================
module tb_sr_flop_bank;

  logic       clk = 1'b0;
  logic       reset, en, cnt_clr;
  logic [7:0] set, clr;

  logic [7:0] q0, qb0, r0, f0;  logic c0; logic [7:0] n0;
  logic [7:0] q1, qb1, r1, f1;  logic c1; logic [7:0] n1;
  logic [7:0] q2, qb2, r2, f2;  logic c2; logic [7:0] n2;
  logic [7:0] q3, qb3, r3, f3;  logic c3; logic [1:0] n3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sr_flop_bank #(.WIDTH(8), .MODE(0), .INIT(8'hA5), .CNT_W(8)) u_m0 (
    .clk(clk), .reset(reset), .en(en), .set(set), .clr(clr), .cnt_clr(cnt_clr),
    .q(q0), .qbar(qb0), .rise(r0), .fall(f0), .conflict(c0), .conflict_cnt(n0));
  sr_flop_bank #(.WIDTH(8), .MODE(1), .INIT(8'h00), .CNT_W(8)) u_m1 (
    .clk(clk), .reset(reset), .en(en), .set(set), .clr(clr), .cnt_clr(cnt_clr),
    .q(q1), .qbar(qb1), .rise(r1), .fall(f1), .conflict(c1), .conflict_cnt(n1));
  sr_flop_bank #(.WIDTH(8), .MODE(2), .INIT(8'h00), .CNT_W(8)) u_m2 (
    .clk(clk), .reset(reset), .en(en), .set(set), .clr(clr), .cnt_clr(cnt_clr),
    .q(q2), .qbar(qb2), .rise(r2), .fall(f2), .conflict(c2), .conflict_cnt(n2));
  sr_flop_bank #(.WIDTH(8), .MODE(3), .INIT(8'h00), .CNT_W(2)) u_m3 (
    .clk(clk), .reset(reset), .en(en), .set(set), .clr(clr), .cnt_clr(cnt_clr),
    .q(q3), .qbar(qb3), .rise(r3), .fall(f3), .conflict(c3), .conflict_cnt(n3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; set = 8'hFF; clr = 8'h00; cnt_clr = 1'b0;
    tick(); tick();
    chk("rst_q0",    32'(q0),  32'hA5);
    chk("rst_qb0",   32'(qb0), 32'h5A);
    chk("rst_rise0", 32'(r0),  32'h00);
    chk("rst_fall0", 32'(f0),  32'h00);
    chk("rst_cnt0",  32'(n0),  32'h00);
    chk("rst_conf0", 32'(c0),  32'h0);
    chk("rst_q3",    32'(q3),  32'h00);
    chk("rst_qb3",   32'(qb3), 32'hFF);

    // set 0F held two cycles: single rise pulse
    reset = 1'b0; set = 8'h0F; clr = 8'h00;
    tick();
    chk("set_q0",    32'(q0),  32'hAF);
    chk("set_rise0", 32'(r0),  32'h0A);
    chk("set_q3",    32'(q3),  32'h0F);
    chk("set_rise3", 32'(r3),  32'h0F);
    chk("set_qb3",   32'(qb3), 32'hF0);
    tick();
    chk("hold_q3",    32'(q3), 32'h0F);
    chk("hold_rise3", 32'(r3), 32'h00);

    set = 8'h00; clr = 8'h03;
    tick();
    chk("clr_q0",    32'(q0), 32'hAC);
    chk("clr_fall0", 32'(f0), 32'h03);
    chk("clr_q3",    32'(q3), 32'h0C);
    chk("clr_fall3", 32'(f3), 32'h03);
    chk("clr_rise3", 32'(r3), 32'h00);

    clr = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_q3",     32'(q3),       32'h0C);
      chk("idle_pulse3", 32'({r3, f3}), 32'h0000);
      chk("idle_conf3",  32'(c3),       32'h0);
    end

    clr = 8'hFF;
    tick();
    chk("zero_q0",    32'(q0), 32'h00);
    chk("zero_fall0", 32'(f0), 32'hAC);
    chk("zero_q1",    32'(q1), 32'h00);
    chk("zero_q3",    32'(q3), 32'h00);

    // five conflict cycles on channel 0
    set = 8'h01; clr = 8'h01;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mode_q0",    32'(q0), 32'h00);
      chk("mode_q1",    32'(q1), 32'h01);
      chk("mode_rise1", 32'(r1), (k == 0) ? 32'h01 : 32'h00);
      chk("mode_q2",    32'(q2), 32'h00);
      chk("mode_q3",    32'(q3), (k % 2 == 0) ? 32'h01 : 32'h00);
      chk("mode_rise3", 32'(r3), (k % 2 == 0) ? 32'h01 : 32'h00);
      chk("mode_fall3", 32'(f3), (k % 2 == 0) ? 32'h00 : 32'h01);
      chk("mode_conf0", 32'(c0), 32'h1);
      chk("mode_conf2", 32'(c2), 32'h1);
      chk("mode_cnt0",  32'(n0), 32'(k + 1));
      chk("mode_cnt3",  32'(n3), (k < 3) ? 32'(k + 1) : 32'h3);
    end

    en = 1'b0; set = 8'hFF; clr = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("en_q0",     32'(q0),       32'h00);
      chk("en_q1",     32'(q1),       32'h01);
      chk("en_q3",     32'(q3),       32'h01);
      chk("en_pulse3", 32'({r3, f3}), 32'h0000);
      chk("en_conf0",  32'(c0),       32'h0);
      chk("en_cnt0",   32'(n0),       32'h05);
      chk("en_cnt3",   32'(n3),       32'h3);
    end

    en = 1'b1; set = 8'h01; clr = 8'h01; cnt_clr = 1'b1;
    tick();
    chk("cclr_cnt0",  32'(n0), 32'h00);
    chk("cclr_cnt3",  32'(n3), 32'h0);
    chk("cclr_conf0", 32'(c0), 32'h1);
    chk("cclr_q3",    32'(q3), 32'h00);
    chk("cclr_fall3", 32'(f3), 32'h01);

    cnt_clr = 1'b0;
    tick();
    chk("post_cnt0",  32'(n0), 32'h01);
    chk("post_cnt3",  32'(n3), 32'h1);
    chk("post_q3",    32'(q3), 32'h01);
    chk("post_rise3", 32'(r3), 32'h01);

    reset = 1'b1;
    tick();
    chk("mrst_q0",    32'(q0),  32'hA5);
    chk("mrst_rise0", 32'(r0),  32'h00);
    chk("mrst_cnt0",  32'(n0),  32'h00);
    chk("mrst_conf0", 32'(c0),  32'h0);
    chk("mrst_q3",    32'(q3),  32'h00);
    chk("mrst_qb3",   32'(qb3), 32'hFF);
    chk("mrst_fall3", 32'(f3),  32'h00);
    chk("mrst_cnt3",  32'(n3),  32'h0);

    reset = 1'b0;
    tick();
    chk("resume_q3",    32'(q3), 32'h01);
    chk("resume_rise3", 32'(r3), 32'h01);
    chk("resume_conf3", 32'(c3), 32'h1);
    chk("resume_cnt3",  32'(n3), 32'h1);
    chk("resume_q0",    32'(q0), 32'hA5);
    chk("resume_cnt0",  32'(n0), 32'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
